// File: rtl/instr_loader.sv
// Instruction loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory, then releases the core to run.
module instr_loader #(
    parameter int ADDR_W    = 8,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              core_run,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                core_run_q, core_run_d;
    logic                err_q, err_d;

    logic                count_ok;
    logic                start_ok;
    logic                byte_accept;
    logic                last_word;

    // A zero-length or oversized session is refused so the address never leaves the memory.
    assign count_ok    = (word_count != '0) && (word_count <= MAX_COUNT);
    assign start_ok    = start && count_ok;
    assign byte_accept = byte_valid && (state_q == S_COLLECT);
    assign last_word   = ({1'b0, addr_q} == (count_q - COUNT_ONE));

    // State and datapath registers; reset clears everything at once, independent of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            wdata_q    <= '0;
            core_run_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            wdata_q    <= wdata_d;
            core_run_q <= core_run_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: abort beats byte acceptance and beats the post-write decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (abort)                                      state_d = S_IDLE;
                else if (byte_accept && (byte_idx_q == 2'd3))   state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort)          state_d = S_IDLE;
                else if (last_word) state_d = S_DONE;
                else                state_d = S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: session setup, byte-lane assembly, address advance, status flags.
    always_comb begin
        count_d    = count_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        wdata_d    = wdata_q;
        core_run_d = core_run_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_ok) begin
                        count_d    = word_count;
                        addr_d     = '0;
                        byte_idx_d = '0;
                        err_d      = 1'b0;
                        core_run_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    // A partial word is dropped; a byte handshaked in this cycle is swallowed.
                    byte_idx_d = '0;
                end else if (byte_accept) begin
                    wdata_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            S_WRITE: begin
                if (!abort) begin
                    if (last_word) core_run_d = 1'b1;
                    else           addr_d     = addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from the registered state only, so reset forces them low immediately.
    always_comb begin
        byte_ready = (state_q == S_COLLECT);
        mem_we     = (state_q == S_WRITE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        core_run   = core_run_q;
        err        = err_q;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction-memory word-address width.
REQ-002 Parameter MEM_WORDS, default 256, SHALL set the instruction-memory depth in 32-bit words.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-low reset: 0 resets, 1 runs.
REQ-005 start  in  1  SHALL be the request to begin a load session; it is sampled only in IDLE.
REQ-006 word_count  in  ADDR_W+1  SHALL give the number of words to load; it is latched on an accepted start.
REQ-007 abort  in  1  SHALL be a synchronous cancel of the current session.
REQ-008 byte_valid  in  1  SHALL indicate that the source is presenting a byte.
REQ-009 byte_data  in  8  SHALL carry the instruction byte, least-significant byte first.
REQ-010 byte_ready  out  1  SHALL indicate that the loader accepts a byte this cycle.
REQ-011 mem_we  out  1  SHALL be the instruction-memory write strobe.
REQ-012 mem_addr  out  ADDR_W  SHALL be the instruction-memory word address.
REQ-013 mem_wdata  out  32  SHALL be the instruction word to write.
REQ-014 busy  out  1  SHALL be high in every state except IDLE.
REQ-015 done  out  1  SHALL pulse for one cycle when a session completes.
REQ-016 core_run  out  1  SHALL be the processor run-enable; the core SHALL fetch only while it is high.
REQ-017 err  out  1  SHALL be a sticky flag indicating that a start was rejected.

Function
REQ-018 The state machine SHALL have the states IDLE, COLLECT, WRITE and DONE; all transitions SHALL be registered.
REQ-019 In IDLE with start=1 and 1<=word_count<=MEM_WORDS, the loader SHALL:
- latch word_count;
- clear the address counter and the byte index;
- clear err and core_run;
- enter COLLECT.
REQ-020 In IDLE with start=1 and word_count=0 or word_count>MEM_WORDS, the loader SHALL set err=1, stay in IDLE, perform no writes and leave core_run unchanged.
REQ-021 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
- byte_ready SHALL be 1 only in COLLECT.
- byte_data SHALL be ignored on every other cycle.
REQ-022 The k-th accepted byte of a word (k=0..3) SHALL be stored at mem_wdata[8k+7:8k], and the byte index SHALL wrap from 3 to 0.
REQ-023 Acceptance of byte 3 SHALL move the state to WRITE on the next edge, so mem_we is asserted exactly one cycle after the last byte is accepted.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle with mem_addr and mem_wdata stable; byte_ready SHALL be 0.
REQ-025 After WRITE, the state SHALL go to DONE if mem_addr equals the latched count minus 1; otherwise mem_addr SHALL increment and the state SHALL return to COLLECT.
REQ-026 In DONE, done SHALL be 1 for one cycle, core_run SHALL be set to 1, and the state SHALL return to IDLE on the next edge.
REQ-027 core_run SHALL stay 1 until the next accepted start.
REQ-028 mem_addr SHALL never exceed MEM_WORDS-1; there is no wrap-around within a session.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 abort=1 in any non-IDLE state SHALL move the state to IDLE on the next edge, with the following effects:
- no write strobe on that edge;
- core_run SHALL stay 0 and done SHALL not pulse;
- a partially collected word SHALL be discarded.
REQ-031 When abort and an accepted byte occur in the same cycle, abort SHALL win and the byte SHALL be consumed but discarded.
REQ-032 When abort occurs in the WRITE cycle, the write SHALL still occur in that cycle, and the state SHALL then go to IDLE.
REQ-033 Source stalls (byte_valid=0) SHALL be allowed indefinitely in COLLECT without loss of collected bytes.

Reset
REQ-034 While reset=0, every output SHALL be 0 (byte_ready, mem_we, mem_addr, mem_wdata, busy, done, core_run, err) and the state SHALL be IDLE, regardless of clk.
REQ-035 Reset asserted mid-session SHALL discard all progress immediately; after reset is released, no write SHALL occur until a new accepted start.

Verification
REQ-036 The bench SHALL cover a single-word load: start with word_count=1, then bytes 0x13,0x05,0x00,0x00 with byte_valid held high. Required: one mem_we at addr 0 with wdata 0x00000513, done pulses on the next cycle, and core_run=1 afterwards.
REQ-037 The bench SHALL cover a three-word load with byte_valid toggled 1,0,1,0. Required: exactly three strobes, at addrs 0,1,2, in order; no byte lost or duplicated; busy high throughout.
REQ-038 The bench SHALL cover a rejected start: start with word_count=0, then with word_count=MEM_WORDS+1. Required: err=1, busy=0, mem_we never asserted.
REQ-039 The bench SHALL cover abort after two bytes of word 1 in a two-word load. Required: IDLE one cycle later, only the addr-0 write occurred, core_run=0, no done pulse.
REQ-040 The bench SHALL cover reset pulled low during COLLECT, asynchronously between clock edges. Required: all outputs are 0 immediately; after release, byte_ready=0 until a new start.
REQ-041 The bench SHALL cover a full-depth load of MEM_WORDS words with an incrementing pattern. Required: the last write is at addr MEM_WORDS-1, done pulses once, and no strobe occurs beyond MEM_WORDS-1.
